// File: rtl/relu_activation_if.sv
// Streaming handshake bundle for the ReLU output stage: upstream data/valid,
// downstream ready, and the registered result returned to the consumer.
interface relu_activation_if #(
   parameter int ACC_W = 64
) ();
   logic signed [ACC_W-1:0] in_data;
   logic                    in_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] out_data;
   logic                    out_valid;

   modport master (
      output in_data,
      output in_valid,
      output out_ready,
      input  out_data,
      input  out_valid
   );

   modport slave (
      input  in_data,
      input  in_valid,
      input  out_ready,
      output out_data,
      output out_valid
   );
endinterface

// File: rtl/relu_activation.sv
// One-entry registered ReLU stage: clamps negative accumulator values to zero
// and presents them downstream through a valid/ready output register.
module relu_activation #(
   parameter int ACC_W = 64
) (
   input logic               clk,
   input logic               rst,
   relu_activation_if.slave  bus
);

   logic accept;

   // The register frees up in the same cycle it hands off, so a continuous
   // ready stream sustains one item per clock.
   assign accept = bus.in_valid && (bus.out_ready || !bus.out_valid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_data  <= '0;
         bus.out_valid <= 1'b0;
      end else if (accept) begin
         bus.out_data  <= bus.in_data[ACC_W-1] ? '0 : bus.in_data;
         bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_relu_activation.sv
// Self-checking bench for relu_activation at ACC_W=16: scoreboard of
// max(x,0) results against the registered output stream.
module tb_relu_activation;

   localparam int W = 16;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic signed [W-1:0] sb[$];

   relu_activation_if #(.ACC_W(W)) bus ();

   relu_activation #(.ACC_W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic signed [W-1:0] relu_ref(input logic signed [W-1:0] x);
      int v;
      v = x;
      return (v < 0) ? '0 : x;
   endfunction

   // Scoreboard update for one clock edge: hand-off first, then capture.
   function automatic void model_edge(input logic iv, input logic signed [W-1:0] d,
                                      input logic rdy);
      bit acc;
      acc = iv && (rdy || sb.size() == 0);
      if (sb.size() != 0 && rdy) void'(sb.pop_front());
      if (acc) sb.push_back(relu_ref(d));
   endfunction

   task automatic drive(input logic iv, input logic signed [W-1:0] d, input logic rdy);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = rdy;
   endtask

   task automatic advance();
      model_edge(bus.in_valid, bus.in_data, bus.out_ready);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(1'b0, '0, 1'b0);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid_async: got %0b expected 0", bus.out_valid);
      end
      checks++;
      if (bus.out_data !== '0) begin
         errors++; $display("FAIL reset_data_async: got %0d expected 0", bus.out_data);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
         errors++;
         $display("FAIL reset_hold: got valid %0b data %0d expected 0/0", bus.out_valid, bus.out_data);
      end
      rst = 1'b0;
      sb.delete();
      // Idle cycles with undefined data must leave the output untouched.
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 'x, 1'b1);
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL idle_x: got valid %0b data %0d expected 0/0", bus.out_valid, bus.out_data);
         end
         advance();
      end
   endtask

   task automatic test_corners();
      logic signed [W-1:0] vin [5];
      logic signed [W-1:0] vexp [5];
      vin  = '{16'sd0, -16'sd1, 16'sd1, 16'sd32767, 16'sh8000};
      vexp = '{16'sd0, 16'sd0, 16'sd1, 16'sd32767, 16'sd0};
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, vin[i], 1'b1);
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL corner_pre_valid[%0d]: got %0b expected 0", i, bus.out_valid);
         end
         advance();
         drive(1'b0, '0, 1'b1);
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== vexp[i]) begin
            errors++;
            $display("FAIL corner[%0d]: got valid %0b data %0d expected 1/%0d",
                     i, bus.out_valid, bus.out_data, vexp[i]);
         end
         advance();
      end
   endtask

   task automatic test_random_gaps();
      int outs;
      int gap;
      outs = 0;
      for (int i = 0; i < 20; i++) begin
         gap = $urandom_range(0, 3);
         for (int c = 0; c <= gap; c++) begin
            if (c == 0) drive(1'b1, W'($urandom), 1'b1);
            else        drive(1'b0, '0, 1'b1);
            @(negedge clk);
            checks++;
            if (bus.out_valid !== (sb.size() != 0)) begin
               errors++;
               $display("FAIL gaps_valid: got %0b expected %0b", bus.out_valid, sb.size() != 0);
            end else if (sb.size() != 0) begin
               outs++;
               checks++;
               if (bus.out_data !== sb[0]) begin
                  errors++; $display("FAIL gaps_data: got %0d expected %0d", bus.out_data, sb[0]);
               end
            end
            advance();
         end
      end
      for (int c = 0; c < 2; c++) begin
         drive(1'b0, '0, 1'b1);
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            outs++;
            checks++;
            if (sb.size() == 0 || bus.out_data !== sb[0]) begin
               errors++; $display("FAIL gaps_tail: got %0d expected queued item", bus.out_data);
            end
         end
         advance();
      end
      checks++;
      if (outs != 20) begin
         errors++; $display("FAIL gaps_count: got %0d outputs expected 20", outs);
      end
   endtask

   task automatic test_back_to_back();
      int run;
      int max_run;
      run = 0;
      max_run = 0;
      for (int c = 0; c < 53; c++) begin
         if (c < 50) drive(1'b1, W'($urandom), 1'b1);
         else        drive(1'b0, '0, 1'b1);
         @(negedge clk);
         checks++;
         if (bus.out_valid !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL burst_valid[%0d]: got %0b expected %0b", c, bus.out_valid, sb.size() != 0);
         end
         if (bus.out_valid === 1'b1) begin
            run++;
            if (run > max_run) max_run = run;
            checks++;
            if (sb.size() == 0 || bus.out_data !== sb[0]) begin
               errors++; $display("FAIL burst_data[%0d]: got %0d", c, bus.out_data);
            end
         end else begin
            run = 0;
         end
         advance();
      end
      checks++;
      if (max_run != 50) begin
         errors++; $display("FAIL burst_run: got %0d consecutive valid expected 50", max_run);
      end
   endtask

   task automatic test_backpressure();
      int   fed;
      int   cyc;
      logic rdy;
      logic iv;
      logic prev_stall;
      logic signed [W-1:0] prev_data;
      fed = 0;
      cyc = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      while ((fed < 10 || sb.size() != 0) && cyc < 200) begin
         rdy = 1'($urandom_range(0, 1));
         iv  = (fed < 10) && ($urandom_range(0, 3) != 0) && (rdy || sb.size() == 0);
         if (iv) fed++;
         drive(iv, W'($urandom), rdy);
         @(negedge clk);
         checks++;
         if (bus.out_valid !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL bp_valid: got %0b expected %0b", bus.out_valid, sb.size() != 0);
         end else if (sb.size() != 0) begin
            checks++;
            if (bus.out_data !== sb[0]) begin
               errors++; $display("FAIL bp_data: got %0d expected %0d", bus.out_data, sb[0]);
            end
         end
         if (prev_stall) begin
            checks++;
            if (bus.out_data !== prev_data) begin
               errors++; $display("FAIL bp_stable: got %0d expected %0d", bus.out_data, prev_data);
            end
         end
         prev_stall = (bus.out_valid === 1'b1) && !rdy;
         prev_data  = bus.out_data;
         advance();
         cyc++;
      end
      checks++;
      if (cyc >= 200) begin
         errors++; $display("FAIL bp_timeout: fed %0d pending %0d expected drained", fed, sb.size());
      end
   endtask

   task automatic test_stall_release();
      drive(1'b1, 16'sd5, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL stall_pre: got valid %0b expected 0", bus.out_valid);
      end
      advance();
      drive(1'b1, 16'sd7, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'sd5) begin
         errors++; $display("FAIL stall_load: got %0b/%0d expected 1/5", bus.out_valid, bus.out_data);
      end
      advance();
      drive(1'b1, 16'sd9, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'sd5) begin
         errors++; $display("FAIL stall_hold: got %0b/%0d expected 1/5", bus.out_valid, bus.out_data);
      end
      advance();
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'sd9) begin
         errors++; $display("FAIL stall_release: got %0b/%0d expected 1/9", bus.out_valid, bus.out_data);
      end
      advance();
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL stall_drain: got valid %0b expected 0", bus.out_valid);
      end
      advance();
   endtask

   task automatic test_reset_midstream();
      drive(1'b1, 16'sd1234, 1'b0);
      advance();
      drive(1'b0, '0, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'sd1234) begin
         errors++; $display("FAIL mid_load: got %0b/%0d expected 1/1234", bus.out_valid, bus.out_data);
      end
      #3 rst = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
         errors++; $display("FAIL mid_reset: got %0b/%0d expected 0/0", bus.out_valid, bus.out_data);
      end
      sb.delete();
      @(posedge clk);
      #2 rst = 1'b0;
      drive(1'b1, 16'sd77, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL mid_post_pre: got valid %0b expected 0", bus.out_valid);
      end
      advance();
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'sd77) begin
         errors++; $display("FAIL mid_first: got %0b/%0d expected 1/77", bus.out_valid, bus.out_data);
      end
      advance();
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL mid_drain: got valid %0b expected 0", bus.out_valid);
      end
      advance();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL end_queue: got %0d pending expected 0", sb.size());
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_corners();
      test_random_gaps();
      test_back_to_back();
      test_backpressure();
      test_stall_release();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/relu_activation.md
RELU_ACTIVATION -- requirements
Module: relu_activation

Interface
REQ-001 The module SHALL have parameter ACC_W, default 64, giving the signed two's-complement data width in bits (legal range 2..128).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port in_data, input, ACC_W bits signed: the upstream accumulator value.
REQ-005 The module SHALL have port in_valid, input, 1 bit: in_data carries a valid item this cycle.
REQ-006 The module SHALL have port out_ready, input, 1 bit: the downstream stage accepts out_data this cycle.
REQ-007 The module SHALL have port out_data, output, ACC_W bits signed: the registered ReLU result.
REQ-008 The module SHALL have port out_valid, output, 1 bit: out_data holds a valid item.
REQ-009 The module SHALL have exactly one clock (clk), and reset SHALL be asynchronous and active-high (rst).

Function
REQ-010 The module SHALL define accept = in_valid AND (out_ready OR NOT out_valid), evaluated combinationally each cycle.
REQ-011 On a rising clk edge with accept=1, out_data SHALL load 0 if in_data is negative (MSB=1), else in_data unchanged; out_valid SHALL be set to 1.
REQ-012 On a rising edge with accept=0 and out_valid=1 and out_ready=1, out_valid SHALL clear to 0, and out_data SHALL hold its value.
REQ-013 On a rising edge with out_valid=1 and out_ready=0, out_data and out_valid SHALL hold; any in_valid item presented that cycle SHALL NOT be captured, and upstream is responsible for not presenting it.
REQ-014 Latency SHALL be exactly one clock: an item accepted at edge N SHALL appear on out_data/out_valid immediately after edge N.
REQ-015 Throughput SHALL be one item per clock when out_ready=1 continuously: simultaneous output handshake and input accept in the same cycle SHALL replace the output register with no bubble.
REQ-016 The output register SHALL be one entry deep; no item SHALL be duplicated, reordered or lost once accepted.
REQ-017 The comparison SHALL be signed over the full ACC_W width: zero passes as 0; the most negative value (-2^(ACC_W-1)) SHALL yield 0; the maximum positive value (2^(ACC_W-1)-1) SHALL pass unchanged.
REQ-018 The datapath SHALL contain no arithmetic other than the sign test and select, with no saturation or rounding, and out_data width SHALL equal in_data width.
REQ-019 The module SHALL be treated as having no combinational path from in_data to out_data, with outputs driven directly from flops.
REQ-020 X on in_data while in_valid=0 SHALL NOT propagate into out_data or out_valid.

Reset
REQ-021 While rst=1, out_valid SHALL be 0 and out_data SHALL be 0, asynchronously (without waiting for clk).
REQ-022 Asserting rst mid-stream SHALL discard any held item; after rst deasserts, the first accepted item SHALL be processed per REQ-011 on the next edge.
REQ-023 In the first edge after rst deasserts, the module SHALL accept input with out_valid=0, so accept equals in_valid.

Verification
REQ-024 The bench SHALL cover corners, with ACC_W=16 and out_ready=1, driving single-cycle in_valid with 0, -1, 1, 32767 and -32768, requiring out_data 0, 0, 1, 32767 and 0 in order, each one cycle after input.
REQ-025 The bench SHALL cover random gaps: 20 random values with 0-3 idle cycles between them, requiring each output to equal max(in,0), out_valid high for exactly one cycle per item, and no spurious outputs.
REQ-026 The bench SHALL cover a burst of 50 back-to-back random values with out_ready=1, requiring 50 consecutive out_valid cycles with correct values and no bubbles.
REQ-027 The bench SHALL cover backpressure: with out_ready toggled randomly while feeding 10 values, a scoreboard that pushes on accept and pops on out_valid AND out_ready SHALL record zero mismatches, and out_data SHALL be stable whenever out_valid=1 and out_ready=0.
REQ-028 The bench SHALL cover stall then release: with out_valid=1 (value 5) and out_ready=0, presenting in_valid with 7 SHALL leave out_data=5; raising out_ready with in_valid and 9 SHALL pass 5 and then present 9 next cycle.
REQ-029 The bench SHALL cover reset mid-stream: asserting rst between clock edges while out_valid=1 SHALL drive out_valid=0 and out_data=0 immediately, and the scoreboard is flushed and the end-of-test queue is empty.
